// File: rtl/obi_copy_master.sv
// OBI initiator that copies a block of 32-bit words from a source to a destination
// address, one transaction outstanding at a time (read, then write, per word).
module obi_copy_master #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_words_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             obi_req_o,
   input  logic             obi_gnt_i,
   output logic [31:0]      obi_addr_o,
   output logic             obi_we_o,
   output logic [3:0]       obi_be_o,
   output logic [31:0]      obi_wdata_o,
   input  logic             obi_rvalid_i,
   input  logic [31:0]      obi_rdata_i,
   input  logic             obi_err_i
);

   // state   | meaning
   // IDLE    | waiting for start_i
   // RD_REQ  | read request on src pointer, held until grant
   // RD_WAIT | waiting for read response, captures data
   // WR_REQ  | write request on dst pointer, held until grant
   // WR_WAIT | waiting for write response, advances pointers
   // FINISH  | one cycle; schedules done_o/err_o, drops busy_o
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      FINISH  = 3'd5
   } state_e;

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             abort_q, abort_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         wdata_q <= '0;
         abort_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         wdata_q <= wdata_d;
         abort_q <= abort_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      wdata_d = wdata_q;
      abort_d = abort_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            // done_q high means the previous copy is being reported this cycle
            if (start_i && !done_q) begin
               src_d   = {src_addr_i[31:2], 2'b00};
               dst_d   = {dst_addr_i[31:2], 2'b00};
               rem_d   = len_words_i;
               abort_d = 1'b0;
               busy_d  = 1'b1;
               state_d = (len_words_i == '0) ? FINISH : RD_REQ;
            end
         end
         RD_REQ: begin
            if (obi_gnt_i) begin
               abort_d = obi_err_i;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (obi_rvalid_i) begin
               if (abort_q) begin
                  state_d = FINISH;
               end else begin
                  wdata_d = obi_rdata_i;
                  state_d = WR_REQ;
               end
            end
         end
         WR_REQ: begin
            if (obi_gnt_i) begin
               abort_d = obi_err_i;
               state_d = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (obi_rvalid_i) begin
               src_d   = src_q + 32'd4;
               dst_d   = dst_q + 32'd4;
               rem_d   = rem_q - LEN_ONE;
               state_d = (abort_q || rem_q == LEN_ONE) ? FINISH : RD_REQ;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            err_d   = abort_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign obi_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
   assign obi_we_o    = (state_q == WR_REQ);
   assign obi_addr_o  = (state_q == WR_REQ) ? dst_q : src_q;
   assign obi_be_o    = 4'hF;
   assign obi_wdata_o = wdata_q;

endmodule
